// File: rtl/ysyx_23060191_wb_arb.sv
// Write-back arbiter and busy-register scoreboard for the 32-entry GPR file.
// Define YSYX_23060191_WBARB_RR_EN for round-robin arbitration; otherwise fixed priority LSU > ALU > CSR.
module ysyx_23060191_wb_arb #(
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [2:0]      req_valid,
   output logic [2:0]      req_ready,
   input  logic [14:0]     req_rd,
   input  logic [3*DW-1:0] req_data,
   output logic            gpr_wen,
   output logic [4:0]      gpr_waddr,
   output logic [DW-1:0]   gpr_wdata,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   output logic            iss_ready,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   output logic            rs1_busy,
   output logic            rs2_busy
);

   logic          grant_any;
   logic [1:0]    grant_idx;
   logic          xfer;
   logic [4:0]    win_rd;
   logic [DW-1:0] win_data;
   logic [31:0]   busy;
   logic [31:0]   busy_next;
   logic          iss_set;

`ifdef YSYX_23060191_WBARB_RR_EN
   logic [1:0] last;
   logic [1:0] start;
   logic [2:0] cand;

   // Search the three requesters starting just after the last winner.
   always_comb begin
      start     = (last == 2'd2) ? 2'd0 : last + 2'd1;
      grant_any = 1'b0;
      grant_idx = 2'd0;
      cand      = 3'd0;
      for (int k = 0; k < 3; k++) begin
         cand = {1'b0, start} + 3'(k);
         if (cand >= 3'd3) begin
            cand = cand - 3'd3;
         end
         if (!grant_any && req_valid[cand[1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last <= 2'd2;
      end else if (xfer) begin
         last <= grant_idx;
      end
   end
`else
   always_comb begin
      grant_any = |req_valid;
      grant_idx = 2'd0;
      if (req_valid[0]) begin
         grant_idx = 2'd0;
      end else if (req_valid[1]) begin
         grant_idx = 2'd1;
      end else if (req_valid[2]) begin
         grant_idx = 2'd2;
      end
   end
`endif

   // No grant is offered while reset is held, so nothing can be accepted and then lost.
   assign xfer      = grant_any & rst_n;
   assign req_ready = xfer ? (3'b001 << grant_idx) : 3'b000;

   always_comb begin
      win_rd   = req_rd[14:10];
      win_data = req_data[3*DW-1:2*DW];
      case (grant_idx)
         2'd0: begin
            win_rd   = req_rd[4:0];
            win_data = req_data[DW-1:0];
         end
         2'd1: begin
            win_rd   = req_rd[9:5];
            win_data = req_data[2*DW-1:DW];
         end
         default: begin
            win_rd   = req_rd[14:10];
            win_data = req_data[3*DW-1:2*DW];
         end
      endcase
   end

   // Writes to x0 still load address/data but never raise the enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gpr_wen   <= 1'b0;
         gpr_waddr <= 5'd0;
         gpr_wdata <= '0;
      end else begin
         gpr_wen <= xfer && (win_rd != 5'd0);
         if (xfer) begin
            gpr_waddr <= win_rd;
            gpr_wdata <= win_data;
         end
      end
   end

   assign iss_ready = ~busy[iss_rd];
   assign iss_set   = iss_valid & iss_ready & (iss_rd != 5'd0);
   assign rs1_busy  = busy[rs1];
   assign rs2_busy  = busy[rs2];

   // Clear is applied before set so a same-address collision leaves the bit set.
   always_comb begin
      busy_next = busy;
      if (xfer && (win_rd != 5'd0)) begin
         busy_next[win_rd] = 1'b0;
      end
      if (iss_set) begin
         busy_next[iss_rd] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy <= 32'd0;
      end else begin
         busy <= busy_next;
      end
   end

endmodule

// File: tb/tb_ysyx_23060191_wb_arb.sv
// Bench for ysyx_23060191_wb_arb: directed vector table, corner sequences, and a randomized
// run against a behavioural model; honours YSYX_23060191_WBARB_RR_EN like the design.
module tb_ysyx_23060191_wb_arb;

   localparam int DW = 32;

   logic            clk;
   logic            rst_n;
   logic [2:0]      req_valid;
   logic [2:0]      req_ready;
   logic [14:0]     req_rd;
   logic [3*DW-1:0] req_data;
   logic            gpr_wen;
   logic [4:0]      gpr_waddr;
   logic [DW-1:0]   gpr_wdata;
   logic            iss_valid;
   logic [4:0]      iss_rd;
   logic            iss_ready;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic            rs1_busy;
   logic            rs2_busy;

   int testsRun;
   int testsFailed;

   ysyx_23060191_wb_arb #(.DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rd    (req_rd),
      .req_data  (req_data),
      .gpr_wen   (gpr_wen),
      .gpr_waddr (gpr_waddr),
      .gpr_wdata (gpr_wdata),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .iss_ready (iss_ready),
      .rs1       (rs1),
      .rs2       (rs2),
      .rs1_busy  (rs1_busy),
      .rs2_busy  (rs2_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [2:0]  valid;
      logic [4:0]  rd0, rd1, rd2;
      logic [31:0] d0, d1, d2;
      logic        iv;
      logic [4:0]  ird, r1, r2;
      logic [2:0]  eReady;
      logic        eIss, eR1, eR2, eWen;
      logic [4:0]  eWaddr;
      logic [31:0] eWdata;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(logic rst, logic [2:0] valid, logic [4:0] rd0, logic [4:0] rd1,
                               logic [4:0] rd2, logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                               logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2,
                               logic [2:0] eReady, logic eIss, logic eR1, logic eR2,
                               logic eWen, logic [4:0] eWaddr, logic [31:0] eWdata);
      vec_t v;
      v.rst = rst; v.valid = valid; v.rd0 = rd0; v.rd1 = rd1; v.rd2 = rd2;
      v.d0 = d0; v.d1 = d1; v.d2 = d2; v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
      v.eReady = eReady; v.eIss = eIss; v.eR1 = eR1; v.eR2 = eR2;
      v.eWen = eWen; v.eWaddr = eWaddr; v.eWdata = eWdata;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic [2:0] valid,
                                input logic [4:0] rd0, input logic [4:0] rd1, input logic [4:0] rd2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic iv, input logic [4:0] ird,
                                input logic [4:0] r1, input logic [4:0] r2);
      rst_n     = rst;
      req_valid = valid;
      req_rd    = {rd2, rd1, rd0};
      req_data  = {d2, d1, d0};
      iss_valid = iv;
      iss_rd    = ird;
      rs1       = r1;
      rs2       = r2;
   endtask

   // Behavioural reference: scoreboard as a bit array, arbitration as a search order.
   bit          mBusy[32];
   int          mLast;
   bit          mWen;
   logic [4:0]  mWaddr;
   logic [31:0] mWdata;

   function automatic int modelGrant();
      int g;
      g = -1;
      if (!rst_n) return -1;
`ifdef YSYX_23060191_WBARB_RR_EN
      for (int k = 0; k < 3; k++) begin
         int c;
         c = (mLast + 1 + k) % 3;
         if (g < 0 && req_valid[c]) g = c;
      end
`else
      for (int k = 0; k < 3; k++) begin
         if (g < 0 && req_valid[k]) g = k;
      end
`endif
      return g;
   endfunction

   task automatic modelReset();
      foreach (mBusy[i]) mBusy[i] = 1'b0;
      mLast  = 2;
      mWen   = 1'b0;
      mWaddr = 5'd0;
      mWdata = 32'd0;
   endtask

   task automatic randomCycle(input int n);
      int          g;
      bit          issOk;
      logic [2:0]  expReady;
      logic [4:0]  grd;
      logic [31:0] gdata;
      applyStimulus(($urandom_range(0, 40) != 0), 3'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      #2;
      g        = modelGrant();
      expReady = (g < 0) ? 3'b000 : 3'(1 << g);
      issOk    = !mBusy[iss_rd];
      checkOutput($sformatf("rnd%0d ready", n), 64'(req_ready), 64'(expReady));
      checkOutput($sformatf("rnd%0d iss_ready", n), 64'(iss_ready), 64'(issOk));
      checkOutput($sformatf("rnd%0d rs1_busy", n), 64'(rs1_busy), 64'(mBusy[rs1]));
      checkOutput($sformatf("rnd%0d rs2_busy", n), 64'(rs2_busy), 64'(mBusy[rs2]));
      if (!rst_n) begin
         modelReset();
      end else begin
         mWen = 1'b0;
         if (g >= 0) begin
            grd    = req_rd[g*5 +: 5];
            gdata  = req_data[g*DW +: DW];
            mWen   = (grd != 5'd0);
            mWaddr = grd;
            mWdata = gdata;
            mLast  = g;
            if (grd != 5'd0) mBusy[grd] = 1'b0;
         end
         if (iss_valid && issOk && iss_rd != 5'd0) mBusy[iss_rd] = 1'b1;
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("rnd%0d wen", n), 64'(gpr_wen), 64'(mWen));
      checkOutput($sformatf("rnd%0d waddr", n), 64'(gpr_waddr), 64'(mWaddr));
      checkOutput($sformatf("rnd%0d wdata", n), 64'(gpr_wdata), 64'(mWdata));
   endtask

   initial begin
      logic [2:0] expSeq[6];
      testsRun    = 0;
      testsFailed = 0;

      vecs[0]  = mk(0, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 32'h0);
      vecs[1]  = mk(0, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 32'h0);
      vecs[2]  = mk(1, 3'b010, 0, 5, 0, 0, 32'h1234_5678, 0, 0, 0, 0, 0,
                    3'b010, 1, 0, 0, 1, 5, 32'h1234_5678);
      vecs[3]  = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 5, 32'h1234_5678);
      vecs[4]  = mk(1, 3'b001, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0,
                    3'b001, 1, 0, 0, 0, 0, 32'hFFFF_FFFF);
      vecs[5]  = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 3'b000, 1, 0, 0, 0, 0, 32'hFFFF_FFFF);
      vecs[6]  = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 7, 7, 7, 3'b000, 0, 1, 1, 0, 0, 32'hFFFF_FFFF);
      vecs[7]  = mk(1, 3'b010, 0, 7, 0, 0, 32'hA5A5_0007, 0, 0, 0, 7, 0,
                    3'b010, 1, 1, 0, 1, 7, 32'hA5A5_0007);
      vecs[8]  = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 7, 7, 0, 3'b000, 1, 0, 0, 0, 7, 32'hA5A5_0007);
      vecs[9]  = mk(1, 3'b010, 0, 7, 0, 0, 32'h0000_7777, 0, 1, 7, 7, 0,
                    3'b010, 1, 0, 0, 1, 7, 32'h0000_7777);
      vecs[10] = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 7, 7, 0, 3'b000, 0, 1, 0, 0, 7, 32'h0000_7777);
      vecs[11] = mk(1, 3'b100, 0, 0, 7, 0, 0, 32'hC5C5_C5C5, 1, 9, 7, 9,
                    3'b100, 1, 1, 0, 1, 7, 32'hC5C5_C5C5);
      vecs[12] = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 7, 9, 3'b000, 1, 0, 1, 0, 7, 32'hC5C5_C5C5);

      applyStimulus(0, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].rd0, vecs[i].rd1, vecs[i].rd2,
                       vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].iv, vecs[i].ird,
                       vecs[i].r1, vecs[i].r2);
         #2;
         checkOutput($sformatf("row%0d ready", i), 64'(req_ready), 64'(vecs[i].eReady));
         checkOutput($sformatf("row%0d iss_ready", i), 64'(iss_ready), 64'(vecs[i].eIss));
         checkOutput($sformatf("row%0d rs1_busy", i), 64'(rs1_busy), 64'(vecs[i].eR1));
         checkOutput($sformatf("row%0d rs2_busy", i), 64'(rs2_busy), 64'(vecs[i].eR2));
         @(posedge clk);
         #1;
         checkOutput($sformatf("row%0d wen", i), 64'(gpr_wen), 64'(vecs[i].eWen));
         checkOutput($sformatf("row%0d waddr", i), 64'(gpr_waddr), 64'(vecs[i].eWaddr));
         checkOutput($sformatf("row%0d wdata", i), 64'(gpr_wdata), 64'(vecs[i].eWdata));
      end

      // Reset lands at the edge that would have captured an accepted rd=3 result.
      applyStimulus(1, 3'b001, 3, 0, 0, 32'h33, 0, 0, 0, 0, 9, 9);
      #2;
      checkOutput("midrst ready", 64'(req_ready), 64'(3'b001));
      checkOutput("midrst busy9 before", 64'(rs2_busy), 64'(1'b1));
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midrst wen", 64'(gpr_wen), 64'(1'b0));
      checkOutput("midrst waddr", 64'(gpr_waddr), 64'(5'd0));
      checkOutput("midrst busy9 after", 64'(rs2_busy), 64'(1'b0));

      // Full contention straight out of reset.
`ifdef YSYX_23060191_WBARB_RR_EN
      expSeq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
      expSeq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 0, 0, 0);
         #2;
         checkOutput($sformatf("contend%0d ready", c), 64'(req_ready), 64'(expSeq[c]));
         @(posedge clk);
         #1;
         checkOutput($sformatf("contend%0d wen", c), 64'(gpr_wen), 64'(1'b1));
         checkOutput($sformatf("contend%0d waddr", c), 64'(gpr_waddr),
                     64'((expSeq[c] == 3'b001) ? 5'd1 : (expSeq[c] == 3'b010) ? 5'd2 : 5'd3));
      end

      modelReset();
      applyStimulus(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      for (int n = 0; n < 400; n++) begin
         randomCycle(n);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ysyx_23060191_wb_arb.md
# ysyx_23060191_wb_arb

Write-back arbiter and scoreboard for the 32-entry general-purpose register file. It shares the register file's single write port among three result producers (LSU, ALU, CSR unit) through valid/ready handshakes, and drives one registered write per cycle into the register file. It also tracks in-flight destination registers so that decode can detect RAW and WAW hazards on `rs1`, `rs2` and `rd`.

## Interface
- `DW`, default 32: data width; equals `CPU_WIDTH`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  3  per-requester valid; [0]=LSU, [1]=ALU, [2]=CSR.
- `req_ready`  out  3  per-requester ready; one-hot or zero.
- `req_rd`  in  15  packed destination addresses, 5 bits per requester (requester i uses [5i+4:5i]).
- `req_data`  in  3*DW  packed write data, DW bits per requester.
- `gpr_wen`  out  1  register-file write enable (registered).
- `gpr_waddr`  out  5  register-file write address (registered).
- `gpr_wdata`  out  DW  register-file write data (registered).
- `iss_valid`  in  1  decode issues an instruction that will write `iss_rd`.
- `iss_rd`  in  5  destination of the issuing instruction.
- `iss_ready`  out  1  0 when `iss_rd` is already busy (WAW stall).
- `rs1`, `rs2`  in  5 each  decode source addresses.
- `rs1_busy`, `rs2_busy`  out  1 each  source has a pending write (RAW stall).

## Operation
- Arbitration is combinational over `req_valid`. At most one `req_ready` bit is high per cycle. A transfer is `req_valid[i] & req_ready[i]`.
- Round-robin mode: the search starts at `(last+1) mod 3`, where `last` is the index of the most recent granted requester. `last` updates only on a transfer.
- Fixed mode: priority is 0 > 1 > 2.
- Output stage:
  - A transfer in cycle N loads `gpr_waddr`/`gpr_wdata` from the winner and sets `gpr_wen`=1 in cycle N+1.
  - If there is no transfer in cycle N, `gpr_wen`=0 in cycle N+1.
  - When `gpr_wen`=0, `gpr_waddr` and `gpr_wdata` hold their previous values.
- rd=0: the handshake completes normally, but `gpr_wen` stays 0. `gpr_waddr` and `gpr_wdata` still load.
- Scoreboard: a 32-bit vector `busy`. Bit 0 is hardwired to 0.
  - Set: `iss_valid & iss_ready & iss_rd!=0` sets `busy[iss_rd]`.
  - Clear: a transfer with rd≠0 clears `busy[rd]`.
  - Set and clear of the same address in the same cycle: set wins, bit stays 1.
  - Set and clear of different addresses in the same cycle: both are applied.
- `iss_ready` = `~busy[iss_rd]`. It is 1 when `iss_rd`=0.
- `rs1_busy` = `busy[rs1]`; `rs2_busy` = `busy[rs2]`. Both are combinational on the current `busy` vector.
- A requester must hold `req_valid`, `req_rd` and `req_data` stable until its transfer. The arbiter does not check this.

## Timing
- Reset values (while `rst_n`=0 at an edge): `gpr_wen`=0, `gpr_waddr`=0, `gpr_wdata`=0, `busy`=0, `last`=2, so requester 0 has highest priority first.
- `req_ready`=0 during any cycle in which `rst_n`=0.
- Reset asserted mid-operation: an accepted-but-unwritten result in the output stage is dropped (`gpr_wen`=0 next cycle). All busy bits clear.
- Latency from request to register-file write is 1 cycle. The register file sees `gpr_wen`, `gpr_waddr` and `gpr_wdata` during cycle N+1.
- Throughput is one write per cycle. No bubble is inserted between back-to-back grants.
- Scoreboard clear is visible from cycle N+1, the same cycle the write is presented. Decode may therefore read the register in N+1 through the combinational register-file path.
- Issue in cycle N makes `rs1_busy`/`rs2_busy` reflect the set from cycle N+1. There is no same-cycle bypass.
- A requester starved by fixed priority has no timeout. Fairness is guaranteed only in round-robin mode: maximum wait is 2 grants.

## Configuration
- Macro: `YSYX_23060191_WBARB_RR_EN`.
- Defined: round-robin arbitration with the `last` pointer as specified above.
- Undefined: fixed priority LSU > ALU > CSR. The `last` register is not implemented. All other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with all `req_valid`=3'b111. Required: `req_ready`=0, `gpr_wen`=0, `rs1_busy`=`rs2_busy`=0.
- Single write: ALU request rd=5, data=0x1234_5678 in cycle N. Required: `req_ready`=3'b010 in N; in N+1, `gpr_wen`=1, `gpr_waddr`=5, `gpr_wdata`=0x12345678; in N+2, `gpr_wen`=0.
- Contention with RR enabled: all three valid for 6 cycles after reset. Required: grant order 0,1,2,0,1,2. With RR disabled: 0 is granted every cycle and requesters 1 and 2 remain stalled.
- Writes to x0: LSU request rd=0, data=0xFFFFFFFF. Required: handshake completes and `gpr_wen`=0 next cycle. Issue with `iss_rd`=0: `iss_ready`=1 and `busy` is unchanged.
- Scoreboard:
  - Issue rd=7, then `rs1`=7. Required: `rs1_busy`=1 and `iss_ready`=0 for `iss_rd`=7.
  - ALU write-back of rd=7. Required: `rs1_busy`=0 from the next cycle.
  - Same-cycle issue rd=7 and write-back rd=7. Required: `busy[7]` remains 1.
- Reset mid-flight: transfer of rd=3 in cycle N with `rst_n`=0 at the end of N. Required: `gpr_wen`=0 in N+1 and `busy` all zero.
